sha256_stream_core: RTL

- Parametrised successor of the fixed-size SHA-256 engine used by the bitcoin_hash top level.
- Accepts a pre-padded message of 1..MAX_BLOCKS 512-bit blocks as a word stream over a valid/ready handshake.
- Chains the compression function across blocks from a selectable initial hash (standard IV or caller-supplied midstate) and presents a 256-bit digest with a done pulse.
- Sits between the message fetch logic and the nonce/compare logic of bitcoin_hash.

---
 rtl/sha256_pkg.sv | 37 +++
 rtl/sha256_stream_core_msg_sched.sv | 21 ++
 rtl/sha256_stream_core.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 round constants, initial hash, FSM state codes and round/sigma helper functions
package sha256_pkg;
  typedef logic [7:0][31:0] hash_t;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_COMPUTE = 3'd2, S_ADD = 3'd3, S_FINISH = 3'd4;
  localparam hash_t IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                          32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  function automatic logic [31:0] rightrotate(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] big_sigma0(logic [31:0] x);
    return rightrotate(x, 2) ^ rightrotate(x, 13) ^ rightrotate(x, 22);
  endfunction
  function automatic logic [31:0] big_sigma1(logic [31:0] x);
    return rightrotate(x, 6) ^ rightrotate(x, 11) ^ rightrotate(x, 25);
  endfunction
  function automatic logic [31:0] small_sigma0(logic [31:0] x);
    return rightrotate(x, 7) ^ rightrotate(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] small_sigma1(logic [31:0] x);
    return rightrotate(x, 17) ^ rightrotate(x, 19) ^ (x >> 10);
  endfunction
  function automatic hash_t sha_round(hash_t v, logic [31:0] k, logic [31:0] w);
    logic [31:0] t1, t2;
    t1 = v[7] + big_sigma1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k + w;
    t2 = big_sigma0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    return {v[6], v[5], v[4], v[3] + t1, v[2], v[1], v[0], t1 + t2};
  endfunction
endpackage

// File: rtl/sha256_stream_core_msg_sched.sv
// sha256_msg_sched: 16-word message window (clk, load_i/load_w_i parallel load, push_i/push_word_i stream-in, shift_i expand, w0_o current word)
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              load_i,
  input  logic [15:0][31:0] load_w_i,
  input  logic              push_i,
  input  logic [31:0]       push_word_i,
  input  logic              shift_i,
  output logic [31:0]       w0_o
);
  logic [15:0][31:0] w_q, w_d;
  logic [31:0] nw;
  always_comb begin
    nw = push_i ? push_word_i : small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
    w_d = load_i ? load_w_i : (push_i || shift_i) ? {nw, w_q[15:1]} : w_q;
  end
  always_ff @(posedge clk) w_q <= w_d;
  assign w0_o = w_q[0];
endmodule

// File: rtl/sha256_stream_core.sv
// sha256_stream_core: streaming multi-block SHA-256 (clk, reset_n, start/num_blocks/use_h_in/h_in, in_valid/in_word/in_ready, busy/done/digest); SHA256_STREAM_DOUBLE_HASH_EN adds dbl_hash
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int MAX_BLOCKS = 4,
  localparam int BLK_W = $clog2(MAX_BLOCKS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [BLK_W-1:0] num_blocks,
  input  logic             use_h_in,
  input  logic [7:0][31:0] h_in,
`ifdef SHA256_STREAM_DOUBLE_HASH_EN
  input  logic             dbl_hash,
`endif
  input  logic             in_valid,
  input  logic [31:0]      in_word,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [7:0][31:0] digest
);
  logic [2:0] state_q, state_d;
  logic [BLK_W-1:0] nb_q, nb_d, blk_q, blk_d;
  logic [5:0] cnt_q, cnt_d;
  hash_t h_q, h_d, v_q, v_d, digest_q, digest_d, init, h_sum;
  logic dbl_q, dbl_d, pass_q, pass_d, done_q, done_d, last_blk, sched_load;
  logic [31:0] w0;
  sha256_msg_sched u_sched (
    .clk         (clk),
    .load_i      (sched_load),
    .load_w_i    ({32'h00000100, {6{32'h0}}, 32'h80000000, h_sum}),
    .push_i      (state_q == S_LOAD && in_valid),
    .push_word_i (in_word),
    .shift_i     (state_q == S_COMPUTE),
    .w0_o        (w0)
  );
  always_comb begin
    state_d = state_q;
    nb_d = nb_q;
    blk_d = blk_q;
    cnt_d = cnt_q;
    h_d = h_q;
    v_d = v_q;
    dbl_d = dbl_q;
    pass_d = pass_q;
    digest_d = digest_q;
    done_d = 1'b0;
    sched_load = 1'b0;
    init = use_h_in ? h_in : IV;
    for (int i = 0; i < 8; i++) h_sum[i] = h_q[i] + v_q[i];
    last_blk = (blk_q + BLK_W'(1)) == nb_q;
    case (state_q)
      S_IDLE: if (start) begin
        h_d = init;
        v_d = init;
        nb_d = num_blocks > BLK_W'(MAX_BLOCKS) ? BLK_W'(MAX_BLOCKS) : num_blocks;
        blk_d = '0;
        cnt_d = '0;
        pass_d = 1'b0;
`ifdef SHA256_STREAM_DOUBLE_HASH_EN
        dbl_d = dbl_hash;
`else
        dbl_d = 1'b0;
`endif
        state_d = num_blocks == '0 ? S_FINISH : S_LOAD;
      end
      S_LOAD: if (in_valid) begin
        cnt_d = cnt_q == 6'd15 ? 6'd0 : cnt_q + 6'd1;
        state_d = cnt_q == 6'd15 ? S_COMPUTE : S_LOAD;
      end
      S_COMPUTE: begin
        v_d = sha_round(v_q, K[cnt_q], w0);
        cnt_d = cnt_q + 6'd1;
        state_d = cnt_q == 6'd63 ? S_ADD : S_COMPUTE;
      end
      S_ADD: begin
        h_d = h_sum;
        v_d = h_sum;
        blk_d = last_blk ? blk_q : blk_q + BLK_W'(1);
        state_d = !last_blk ? S_LOAD : S_FINISH;
        if (last_blk && dbl_q && !pass_q) begin
          // second pass hashes the 32-byte first digest, padded to one block
          sched_load = 1'b1;
          pass_d = 1'b1;
          h_d = IV;
          v_d = IV;
          state_d = S_COMPUTE;
        end
      end
      S_FINISH: begin
        digest_d = h_q;
        done_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      nb_q <= '0;
      blk_q <= '0;
      cnt_q <= '0;
      h_q <= '0;
      v_q <= '0;
      dbl_q <= 1'b0;
      pass_q <= 1'b0;
      digest_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      nb_q <= nb_d;
      blk_q <= blk_d;
      cnt_q <= cnt_d;
      h_q <= h_d;
      v_q <= v_d;
      dbl_q <= dbl_d;
      pass_q <= pass_d;
      digest_q <= digest_d;
      done_q <= done_d;
    end
  end
  assign in_ready = state_q == S_LOAD;
  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign digest = digest_q;
endmodule
